// File: rtl/phv_container_assembler.sv
// Collects one result per ALU lane plus the packet metadata, then presents the
// assembled PHV downstream with a valid/ready handshake.
module phv_container_assembler #(
    parameter int NUM_ALU    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int META_WIDTH = 256,
    parameter logic [NUM_ALU-1:0] ACTIVE_MASK = {NUM_ALU{1'b1}}
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_ALU*DATA_WIDTH-1:0]          alu_data_in,
    input  logic [NUM_ALU-1:0]                     alu_valid_in,
    output logic                                   alu_ready_out,
    input  logic [META_WIDTH-1:0]                  meta_in,
    input  logic                                   meta_valid_in,
    output logic [NUM_ALU*DATA_WIDTH+META_WIDTH-1:0] phv_out,
    output logic                                   phv_valid_out,
    input  logic                                   phv_ready_in,
    output logic                                   dup_err
);

    localparam int CW = NUM_ALU * DATA_WIDTH;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_OUTPUT  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_ALU-1:0]      got_q, got_d;
    logic                    meta_got_q, meta_got_d;
    logic [CW-1:0]           container_q, container_d;
    logic [META_WIDTH-1:0]   meta_q, meta_d;
    logic                    dup_err_q, dup_err_d;
    logic                    phv_valid_q, phv_valid_d;
    logic                    alu_ready_q, alu_ready_d;
    logic [NUM_ALU-1:0]      capture;
    logic                    meta_capture;

    always_comb begin
        state_d      = state_q;
        got_d        = got_q;
        meta_got_d   = meta_got_q;
        dup_err_d    = dup_err_q;
        phv_valid_d  = phv_valid_q;
        alu_ready_d  = alu_ready_q;
        capture      = '0;
        meta_capture = 1'b0;
        case (state_q)
            S_COLLECT: begin
                capture      = alu_valid_in & ~got_q;
                meta_capture = meta_valid_in & ~meta_got_q;
                if ((|(alu_valid_in & got_q)) || (meta_valid_in && meta_got_q))
                    dup_err_d = 1'b1;
                got_d      = got_q | alu_valid_in;
                meta_got_d = meta_got_q | meta_valid_in;
                // Same-cycle arrivals count toward completion.
                if ((&got_d) && meta_got_d) begin
                    state_d     = S_OUTPUT;
                    phv_valid_d = 1'b1;
                    alu_ready_d = 1'b0;
                end
            end
            S_OUTPUT: begin
                if ((|alu_valid_in) || meta_valid_in)
                    dup_err_d = 1'b1;
                if (phv_ready_in) begin
                    state_d     = S_COLLECT;
                    got_d       = ~ACTIVE_MASK;
                    meta_got_d  = 1'b0;
                    phv_valid_d = 1'b0;
                    alu_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    // Inactive lanes are never captured, so their containers stay at zero.
    generate
        for (genvar gi = 0; gi < NUM_ALU; gi++) begin : g_lane
            assign container_d[gi*DATA_WIDTH +: DATA_WIDTH] =
                capture[gi] ? alu_data_in[gi*DATA_WIDTH +: DATA_WIDTH]
                            : container_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign meta_d = meta_capture ? meta_in : meta_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            got_q       <= ~ACTIVE_MASK;
            meta_got_q  <= 1'b0;
            container_q <= '0;
            meta_q      <= '0;
            dup_err_q   <= 1'b0;
            phv_valid_q <= 1'b0;
            alu_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            got_q       <= got_d;
            meta_got_q  <= meta_got_d;
            container_q <= container_d;
            meta_q      <= meta_d;
            dup_err_q   <= dup_err_d;
            phv_valid_q <= phv_valid_d;
            alu_ready_q <= alu_ready_d;
        end
    end

    assign phv_out       = {meta_q, container_q};
    assign phv_valid_out = phv_valid_q;
    assign alu_ready_out = alu_ready_q;
    assign dup_err       = dup_err_q;

endmodule
